// File: rtl/alu_defs.sv
// Shared definitions for the registered ALU: opcodes and FSM state encodings.
package alu_defs;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier. ld captures the operands; one partial
// product is accumulated per edge. done is high combinationally during the
// last iteration cycle, and {hi,lo} then shows the final product so the
// parent can register it on the same edge that completes the multiply.
module alu_mul_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc_next;

  // Next accumulator value: add the shifted multiplicand when the current
  // multiplier LSB is set.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  assign done = busy && (cnt == LAST);
  assign hi   = acc_next[2*WIDTH-1:WIDTH];
  assign lo   = acc_next[WIDTH-1:0];

  // Iteration registers: reset clears everything, ld restarts, busy iterates.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (ld && !busy) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (cnt == LAST) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with status flags and a start/busy/done handshake.
// Handshake: start is sampled on a rising edge only while busy=0; S/A/B are
// captured on that same edge. done pulses for exactly one cycle when F, FH and
// the flags hold a new result; they hold until the next done. Single-cycle ops
// finish on the start edge; MUL keeps busy high for WIDTH cycles.
module alu_seq
  import alu_defs::*;
#(
  parameter int WIDTH = 4,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       S,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] F,
  output logic [WIDTH-1:0] FH,
  output logic             C,
  output logic             Z,
  output logic             N,
  output logic             V
);

  state_t state_q, state_d;

  logic             mul_ld;
  logic             alu_ld;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] shl_ext;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   alu_f;
  logic               alu_c;
  logic               alu_v;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk  (clk),
    .rst  (rst),
    .ld   (mul_ld),
    .a    (A),
    .b    (B),
    .busy (mul_busy),
    .done (mul_done),
    .hi   (mul_hi),
    .lo   (mul_lo)
  );

  assign busy = mul_busy;

  // Single-cycle datapath; the shift goes through a double-width vector so
  // the last bit shifted out lands at bit WIDTH.
  always_comb begin
    shamt   = B[SHW-1:0];
    sum     = {1'b0, A} + {1'b0, B};
    diff    = {1'b0, A} - {1'b0, B};
    shl_ext = {{WIDTH{1'b0}}, A} << shamt;
    alu_f   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (S)
      OP_ADD: begin
        alu_f = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (A[WIDTH-1] == B[WIDTH-1]) && (alu_f[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_f = diff[WIDTH-1:0];
        alu_c = diff[WIDTH];
        alu_v = (A[WIDTH-1] != B[WIDTH-1]) && (alu_f[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: alu_f = A & B;
      OP_OR:  alu_f = A | B;
      OP_XOR: alu_f = A ^ B;
      OP_NOT: alu_f = ~A;
      OP_SHL: begin
        alu_f = shl_ext[WIDTH-1:0];
        alu_c = (shamt != '0) && shl_ext[WIDTH];
      end
      default: ;
    endcase
  end

  // Next-state logic: accept start only in IDLE, MUL returns on mul_done.
  always_comb begin
    state_d = state_q;
    mul_ld  = 1'b0;
    alu_ld  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (S == OP_MUL) begin
            mul_ld  = 1'b1;
            state_d = ST_MUL;
          end else begin
            alu_ld = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Result/flag registers; loaded only when an op completes, done pulses once.
  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
      F    <= '0;
      FH   <= '0;
      C    <= 1'b0;
      Z    <= 1'b0;
      N    <= 1'b0;
      V    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (alu_ld) begin
        done <= 1'b1;
        F    <= alu_f;
        FH   <= '0;
        C    <= alu_c;
        Z    <= (alu_f == '0);
        N    <= alu_f[WIDTH-1];
        V    <= alu_v;
      end else if (state_q == ST_MUL && mul_done) begin
        done <= 1'b1;
        F    <= mul_lo;
        FH   <= mul_hi;
        C    <= (mul_hi != '0);
        Z    <= (mul_lo == '0);
        N    <= mul_lo[WIDTH-1];
        V    <= (mul_hi != '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=4. Inputs change and outputs are
// sampled on the falling edge, away from the active rising edge.
module tb_alu_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   S = 3'd0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy, done, C, Z, N, V;
  logic [W-1:0] F, FH;

  int tests = 0;
  int fails = 0;

  // Observation vector: {done, busy, F, FH, C, Z, N, V}
  wire [2*W+5:0] obs = {done, busy, F, FH, C, Z, N, V};

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .S(S), .A(A), .B(B),
    .busy(busy), .done(done), .F(F), .FH(FH), .C(C), .Z(Z), .N(N), .V(V)
  );

  // clock
  always #5 clk = ~clk;

  // Drive a one-cycle start and return at the falling edge after its edge.
  task automatic issue(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; S = s; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tests++;
    if (obs !== {1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL reset: got %b exp %b", obs, 14'b0);
    end
  endtask

  task automatic test_add();
    logic [2*W+5:0] exp;
    issue(3'd0, 4'b1100, 4'b0011);
    exp = {1'b1, 1'b0, 4'b1111, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL add: got %b exp %b", obs, exp); end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || F !== 4'b1111) begin
      fails++; $display("FAIL add_hold: got done=%b F=%b exp done=0 F=1111", done, F);
    end
    issue(3'd0, 4'b1000, 4'b1000);
    exp = {1'b1, 1'b0, 4'b0000, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1};
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL add_ovf: got %b exp %b", obs, exp); end
  endtask

  task automatic test_sub();
    logic [2*W+5:0] exp;
    issue(3'd1, 4'b1100, 4'b0011);
    exp = {1'b1, 1'b0, 4'b1001, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL sub: got %b exp %b", obs, exp); end
    issue(3'd1, 4'b0011, 4'b0101);
    exp = {1'b1, 1'b0, 4'b1110, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0};
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL sub_borrow: got %b exp %b", obs, exp); end
  endtask

  task automatic test_shl();
    logic [2*W+5:0] exp;
    issue(3'd6, 4'b1100, 4'b0001);
    exp = {1'b1, 1'b0, 4'b1000, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0};
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL shl1: got %b exp %b", obs, exp); end
    issue(3'd6, 4'b1100, 4'b0000);
    exp = {1'b1, 1'b0, 4'b1100, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL shl0: got %b exp %b", obs, exp); end
    issue(3'd6, 4'b0101, 4'b0011);
    exp = {1'b1, 1'b0, 4'b1000, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL shl3: got %b exp %b", obs, exp); end
  endtask

  task automatic test_mul();
    logic [2*W+5:0] exp;
    int dones;
    dones = 0;
    issue(3'd7, 4'b1100, 4'b0011);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      tests++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        fails++; $display("FAIL mul_busy c%0d: got busy=%b done=%b exp busy=1 done=0", cyc, busy, done);
      end
      if (cyc == 2) begin start = 1'b1; S = 3'd0; A = 4'b0001; B = 4'b0001; end
      else start = 1'b0;
      @(negedge clk);
    end
    exp = {1'b1, 1'b0, 4'b0100, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1};
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL mul_result: got %b exp %b", obs, exp); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    tests++;
    if (dones !== 0 || F !== 4'b0100 || FH !== 4'b0010) begin
      fails++; $display("FAIL mul_single_done: got extra=%0d F=%b FH=%b exp extra=0 F=0100 FH=0010", dones, F, FH);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_f [6];
    exp_f = '{4'b1111, 4'b1001, 4'b0000, 4'b1111, 4'b1111, 4'b0011};
    @(negedge clk);
    A = 4'b1100; B = 4'b0011;
    start = 1'b1; S = 3'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests++;
      if (done !== 1'b1 || F !== exp_f[i] || Z !== (exp_f[i] == 4'b0000) || FH !== 4'h0) begin
        fails++; $display("FAIL b2b op%0d: got done=%b F=%b Z=%b FH=%b exp done=1 F=%b", i, done, F, Z, FH, exp_f[i]);
      end
      if (i < 5) S = 3'(i + 1);
      else start = 1'b0;
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL b2b_end: got done=%b exp 0", done); end
  endtask

  task automatic test_reset_mid_mul();
    logic [2*W+5:0] exp;
    int dones;
    dones = 0;
    issue(3'd7, 4'b1111, 4'b1111);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (obs !== {1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL rst_mid_mul: got %b exp %b", obs, 14'b0);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    tests++;
    if (dones !== 0) begin fails++; $display("FAIL rst_no_done: got %0d active cycles exp 0", dones); end
    issue(3'd0, 4'b0001, 4'b0010);
    exp = {1'b1, 1'b0, 4'b0011, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL rst_then_add: got %b exp %b", obs, exp); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_shl();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 4-bit combinational 8-op ALU (3-bit select S, operands A/B, result F).
- Generalised to WIDTH bits, with C/Z/N/V status flags and a start/busy/done handshake.
- Adds a multi-cycle shift-add multiply that returns a double-width product.
- Sits between the datapath register file and the writeback stage; one operation is in flight at a time.

Parameters:
- WIDTH, 4, operand/result width in bits; legal values 2..32.
- SHW, $clog2(WIDTH), number of B bits used as the shift amount; derived, not overridden.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled on the edge only while busy=0.
- S  in  3  opcode, captured with start.
- A  in  WIDTH  operand A, captured with start.
- B  in  WIDTH  operand B, captured with start.
- busy  out  1  high while a multiply is iterating.
- done  out  1  one-cycle pulse; result and flags valid.
- F  out  WIDTH  result (low half for MUL).
- FH  out  WIDTH  high half of the product for MUL; 0 for all other ops.
- C  out  1  carry/borrow/shift-out/MUL overflow.
- Z  out  1  F==0.
- N  out  1  F[WIDTH-1].
- V  out  1  signed overflow; also MUL overflow.

Behaviour:
- Reset (sync, rst=1 at an edge): state=IDLE; busy=0, done=0, F=0, FH=0, C=Z=N=V=0; multiplier counter and working registers cleared. rst has priority over start.
- Reset mid-MUL: the multiply aborts, no done is produced, and the unit is back in IDLE the next cycle.
- Opcodes:
  - 0 ADD: F=A+B; C=carry out; V=signed overflow.
  - 1 SUB: F=A-B; C=borrow (A<B unsigned); V=signed overflow.
  - 2 AND, 3 OR, 4 XOR: bitwise; C=V=0.
  - 5 NOT: F=~A; C=V=0.
  - 6 SHL: F=A<<B[SHW-1:0]. C=last bit shifted out; C=0 when the shift amount is 0. V=0.
  - 7 MUL: unsigned; {FH,F}=A*B; C=V=(FH!=0).
- FH=0 for every op except MUL. Z and N always derive from F only.
- State machine has two states, IDLE and MUL.
- IDLE, start=1, S!=7:
  - Result and flags are registered at that edge.
  - done=1 for the following cycle; busy stays 0.
  - Back-to-back starts on consecutive cycles are legal, giving one done per start.
- IDLE, start=1, S=7:
  - Latch A, B; clear the product accumulator and counter; busy=1; go to MUL.
  - done=0 on the next cycle unless a previous op's done is still being reported.
- MUL state:
  - One shift-add iteration per edge.
  - On the WIDTH-th iteration edge, load F, FH and flags, set done=1, set busy=0, return to IDLE.
  - done is therefore high exactly WIDTH+1 cycles after the start edge's cycle begins; busy is high for WIDTH cycles.
- start while busy=1 is ignored: no capture, no effect on the running multiply.
- start in the cycle where done=1 (IDLE) is accepted normally.
- Holding: F, FH and flags hold their last values until the next done. done never stays high for more than one cycle per op.
- Widths: all arithmetic is WIDTH bits, with an internal WIDTH+1 bit sum for carry and a 2*WIDTH bit product register. No truncation warnings are acceptable.

Decomposition:
- Shared definitions file alu_defs: opcode constants OP_ADD..OP_MUL (3-bit) and state encodings ST_IDLE and ST_MUL.
- One sub-module, alu_mul_seq: WIDTH-parametrised shift-add multiplier with ld/busy/done and product {hi,lo}. alu_seq instantiates it and muxes its outputs into F/FH/flags.
- Single-cycle ops are inline combinational logic feeding the output registers.

Test Plan (WIDTH=4):
- Reset, then S=0, A=1100, B=0011, start for one cycle -> next cycle done=1, F=1111, FH=0000, C=0, Z=0, N=1, V=0, busy=0.
- S=0, A=1000, B=1000 -> F=0000, C=1, Z=1, N=0, V=1. Then S=1, A=1100, B=0011 -> F=1001, C=0, N=1, V=0.
- S=6, A=1100, B=0001 -> F=1000, C=1. Then S=6, B=0000 -> F=1100, C=0.
- S=7, A=1100, B=0011 -> busy=1 for 4 cycles, then done=1 with FH=0010, F=0100, C=V=1, Z=0. Issue start S=0 at busy cycle 2 -> ignored, exactly one done.
- Run S=0..5 back-to-back with A=1100, B=0011 -> six consecutive done pulses with F = 1111, 1001, 0000, 1111, 1111, 0011.
- Start S=7, assert rst at busy cycle 2 -> next cycle busy=0, done=0, F=0, FH=0; no done follows. Then a fresh ADD works.
